// File: rtl/iscas_bist_pkg.sv
// Shared types and the 32-bit Galois step used by both the stimulus LFSR and the MISR.
package iscas_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_t;

  localparam logic [31:0] POLY32 = 32'h80200003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? POLY32 : 32'h0);
  endfunction

endpackage

// File: rtl/iscas_bist_misr.sv
// OUT_W-input, 32-bit multiple-input signature register with enable and synchronous seed load.
module iscas_bist_misr
  import iscas_bist_pkg::*;
#(
  parameter int          OUT_W     = 19,
  parameter logic [31:0] MISR_SEED = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [OUT_W-1:0] din,
  output logic [31:0]      sig
);

  logic [31:0] din_ext;
  logic [31:0] sig_reg;

  for (genvar gi = 0; gi < 32; gi++) begin : g_ext
    if (gi < OUT_W) begin : g_bit
      assign din_ext[gi] = din[gi];
    end else begin : g_zero
      assign din_ext[gi] = 1'b0;
    end
  end

  // Seed load wins over a step so a restart always begins from a clean signature.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_reg <= MISR_SEED;
    end else if (load) begin
      sig_reg <= MISR_SEED;
    end else if (en) begin
      sig_reg <= lfsr_step(sig_reg) ^ din_ext;
    end
  end

  assign sig = sig_reg;

endmodule

// File: rtl/iscas_bist_ctrl.sv
// BIST sequencer: flush, LFSR stimulus, MISR compaction for one ISCAS89 benchmark.
// Optional golden-signature comparator enabled by defining ISCAS_BIST_GOLDEN_CMP_EN.
module iscas_bist_ctrl
  import iscas_bist_pkg::*;
#(
  parameter int                IN_W         = 18,
  parameter int                OUT_W        = 19,
  parameter int                CNT_W        = 16,
  parameter int                FLUSH_CYCLES = 4,
  parameter logic [IN_W-1:0]   FLUSH_VEC    = 18'h20000,
  parameter logic [31:0]       LFSR_SEED    = 32'h00000001,
  parameter logic [31:0]       MISR_SEED    = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] run_cycles,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
`ifdef ISCAS_BIST_GOLDEN_CMP_EN
  input  logic [31:0]      golden,
  output logic             pass,
`endif
  output logic [31:0]      signature
);

  localparam logic [31:0] LFSR_INIT = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam int          FLUSH_W   = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

  bist_state_t       state_reg;
  logic [IN_W-1:0]   dut_in_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [31:0]       lfsr_reg;
  logic [31:0]       lfsr_next;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  run_len_reg;
  logic [FLUSH_W-1:0] flush_cnt_reg;
  logic              start_ok;
  logic              misr_en;

  assign start_ok  = start && !abort && (state_reg == ST_IDLE || state_reg == ST_DONE);
  assign misr_en   = (state_reg == ST_RUN) && !abort;
  assign lfsr_next = lfsr_step(lfsr_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      dut_in_reg    <= FLUSH_VEC;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      lfsr_reg      <= LFSR_INIT;
      count_reg     <= '0;
      run_len_reg   <= '0;
      flush_cnt_reg <= '0;
    end else if (abort) begin
      state_reg  <= ST_IDLE;
      dut_in_reg <= FLUSH_VEC;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_reg     <= ST_FLUSH;
            run_len_reg   <= run_cycles;
            count_reg     <= '0;
            lfsr_reg      <= LFSR_INIT;
            flush_cnt_reg <= '0;
            busy_reg      <= 1'b1;
            done_reg      <= 1'b0;
            dut_in_reg    <= FLUSH_VEC;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_reg == FLUSH_LAST) begin
            if (run_len_reg == '0) begin
              state_reg <= ST_DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              state_reg  <= ST_RUN;
              dut_in_reg <= lfsr_reg[IN_W-1:0];
            end
          end else begin
            flush_cnt_reg <= flush_cnt_reg + 1'b1;
          end
        end
        ST_RUN: begin
          lfsr_reg  <= lfsr_next;
          count_reg <= count_reg + 1'b1;
          // count_reg stops at run_len-1, so it cannot wrap even at the maximum length.
          if (count_reg == run_len_reg - 1'b1) begin
            state_reg  <= ST_DONE;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            dut_in_reg <= FLUSH_VEC;
          end else begin
            dut_in_reg <= lfsr_next[IN_W-1:0];
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  iscas_bist_misr #(
    .OUT_W     (OUT_W),
    .MISR_SEED (MISR_SEED)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (start_ok),
    .en   (misr_en),
    .din  (dut_out),
    .sig  (signature)
  );

`ifdef ISCAS_BIST_GOLDEN_CMP_EN
  logic [31:0] golden_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      golden_reg <= '0;
    end else if (start_ok) begin
      golden_reg <= golden;
    end
  end

  assign pass = (state_reg == ST_DONE) && (signature == golden_reg);
`endif

  assign dut_in = dut_in_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_iscas_bist_ctrl.sv
// Self-checking bench for iscas_bist_ctrl with a small resetless sequential benchmark stand-in.
module tb_iscas_bist_ctrl;

  localparam int F = 4;
  localparam logic [17:0] FV = 18'h20000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] run_cycles;
  logic [17:0] dut_in;
  logic [18:0] dut_out;
  logic        busy;
  logic        done;
  logic [31:0] signature;
`ifdef ISCAS_BIST_GOLDEN_CMP_EN
  logic [31:0] golden;
  logic        pass;
`endif

  logic        use_toy;
  logic [18:0] stuck;
  logic [7:0]  toy_state = 8'hA5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iscas_bist_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .run_cycles (run_cycles),
    .dut_in     (dut_in),
    .dut_out    (dut_out),
    .busy       (busy),
    .done       (done),
`ifdef ISCAS_BIST_GOLDEN_CMP_EN
    .golden     (golden),
    .pass       (pass),
`endif
    .signature  (signature)
  );

  function automatic logic [31:0] tstep(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic logic [7:0] toy_next(input logic [7:0] s, input logic [17:0] in);
    if (in[17]) return 8'h00;
    return {s[6:0], ^(s & in[7:0])} ^ in[15:8];
  endfunction

  function automatic logic [18:0] toy_out(input logic [7:0] s, input logic [17:0] in);
    return {s, in[10:0] ^ {3'b000, s}};
  endfunction

  // Reference run: flush leaves the benchmark state at zero, then rc RUN steps.
  function automatic logic [31:0] model_sig(input int rc, input bit toy, input logic [18:0] stk);
    logic [31:0] l = 32'h1;
    logic [31:0] m = 32'hFFFFFFFF;
    logic [7:0]  s = 8'h00;
    logic [18:0] o;
    for (int i = 0; i < rc; i++) begin
      o = toy ? (toy_out(s, l[17:0]) & ~stk) : 19'h0;
      m = tstep(m) ^ {13'h0, o};
      s = toy_next(s, l[17:0]);
      l = tstep(l);
    end
    return m;
  endfunction

  always @(posedge clk) toy_state <= toy_next(toy_state, dut_in);

  always_comb begin
    dut_out = 19'h0;
    if (use_toy) dut_out = toy_out(toy_state, dut_in) & ~stuck;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic run_seq(input int rc, output logic [31:0] sig);
    int cyc;
    int bcnt;
    @(negedge clk);
    start = 1'b1;
    run_cycles = rc[15:0];
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    bcnt = 0;
    while (!done && cyc < rc + F + 20) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
    chk("done_latency", 32'(cyc), 32'(rc + F + 1));
    chk("busy_cycles", 32'(bcnt), 32'(rc + F));
    sig = signature;
    repeat (2) @(negedge clk);
    chk("done_held", 32'(done), 32'd1);
    chk("sig_stable", signature, sig);
  endtask

`ifdef ISCAS_BIST_GOLDEN_CMP_EN
  task automatic golden_run(input int rc, input logic [31:0] g, input logic exp_pass);
    int cyc;
    @(negedge clk);
    start = 1'b1;
    run_cycles = rc[15:0];
    golden = g;
    @(negedge clk);
    start = 1'b0;
    golden = 32'h0;
    repeat (6) @(negedge clk);
    chk("pass_in_run", 32'(pass), 32'd0);
    cyc = 7;
    while (!done && cyc < rc + F + 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("pass_in_done", 32'(pass), 32'(exp_pass));
  endtask
`endif

  typedef struct {
    int          rc;
    bit          toy;
    logic [18:0] stk;
    logic [31:0] exp_sig;
  } vec_t;

  vec_t        vt [7];
  logic [31:0] sigs [7];
  logic [31:0] s;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    run_cycles = 16'h0;
    use_toy = 1'b0;
    stuck = 19'h0;
`ifdef ISCAS_BIST_GOLDEN_CMP_EN
    golden = 32'h0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_dut_in", 32'(dut_in), 32'(FV));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sig", signature, 32'hFFFFFFFF);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_dut_in", 32'(dut_in), 32'(FV));
    chk("idle_busy", 32'(busy), 32'd0);

    vt[0] = '{0,    1'b0, 19'h0, 32'hFFFFFFFF};
    vt[1] = '{2,    1'b0, 19'h0, 32'h7FEFFFFE};
    vt[2] = '{1,    1'b0, 19'h0, 32'hFFDFFFFC};
    vt[3] = '{1000, 1'b1, 19'h0, model_sig(1000, 1'b1, 19'h0)};
    vt[4] = '{1000, 1'b1, 19'h0, model_sig(1000, 1'b1, 19'h0)};
    vt[5] = '{1000, 1'b1, 19'h8, model_sig(1000, 1'b1, 19'h8)};
    vt[6] = '{5,    1'b1, 19'h0, model_sig(5, 1'b1, 19'h0)};

    for (int i = 0; i < 7; i++) begin
      use_toy = vt[i].toy;
      stuck = vt[i].stk;
      run_seq(vt[i].rc, sigs[i]);
      chk($sformatf("sig_vec%0d", i), sigs[i], vt[i].exp_sig);
    end
    chk("repeat_identical", sigs[4], sigs[3]);
    total++;
    if (sigs[5] === sigs[3]) begin
      bad++;
      $display("FAIL stuck_differs: got %h want not %h", sigs[5], sigs[3]);
    end else begin
      $display("ok   stuck_differs: %h", sigs[5]);
    end
    use_toy = 1'b0;
    stuck = 19'h0;

    // Stimulus order: four flush cycles, then LFSR seed, then its first step.
    @(negedge clk);
    start = 1'b1;
    run_cycles = 16'd2;
    @(negedge clk);
    start = 1'b0;
    chk("seq_busy_c1", 32'(busy), 32'd1);
    chk("seq_flush_c1", 32'(dut_in), 32'(FV));
    repeat (3) @(negedge clk);
    chk("seq_flush_c4", 32'(dut_in), 32'(FV));
    @(negedge clk);
    chk("seq_run_c5", 32'(dut_in), 32'h00001);
    @(negedge clk);
    chk("seq_run_c6", 32'(dut_in), 32'h00003);
    @(negedge clk);
    chk("seq_done_c7", 32'(done), 32'd1);
    chk("seq_dut_in_c7", 32'(dut_in), 32'(FV));
    chk("seq_sig_c7", signature, 32'h7FEFFFFE);

    // start while running must neither restart nor resample run_cycles.
    @(negedge clk);
    start = 1'b1;
    run_cycles = 16'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    run_cycles = 16'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("ign_done_c11", 32'(done), 32'd1);
    chk("ign_sig", signature, model_sig(6, 1'b0, 19'h0));

    // abort with start in the third RUN cycle.
    @(negedge clk);
    start = 1'b1;
    run_cycles = 16'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_pre_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_dut_in", 32'(dut_in), 32'(FV));
    chk("abort_sig", signature, model_sig(2, 1'b0, 19'h0));
    repeat (3) @(negedge clk);
    chk("abort_start_ignored", 32'(busy), 32'd0);
    run_seq(3, s);
    chk("after_abort_sig", s, model_sig(3, 1'b0, 19'h0));

    // Asynchronous reset mid-run, checked between clock edges.
    use_toy = 1'b1;
    @(negedge clk);
    start = 1'b1;
    run_cycles = 16'd50;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_dut_in", 32'(dut_in), 32'(FV));
    chk("arst_sig", signature, 32'hFFFFFFFF);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_idle", 32'(busy), 32'd0);

`ifdef ISCAS_BIST_GOLDEN_CMP_EN
    stuck = 19'h0;
    golden_run(1000, sigs[3], 1'b1);
    golden_run(1000, sigs[3] ^ 32'h1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
